// File: rtl/score_display_pkg.sv
// score_display_pkg: seven-segment patterns, BCD converter state encoding and
// default timing constants shared by score_display and bin2bcd_seq.
package score_display_pkg;

    localparam int DEF_DIGIT_PERIOD = 100000;
    localparam int DEF_GUARD        = 16;
    localparam int DEF_BLINK_PERIOD = 25000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low patterns, bit0 = a ... bit6 = g; anything above 9 is blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [11:0] add3(input logic [11:0] b);
        add3 = b;
        for (int i = 0; i < 3; i++)
            add3[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-bit binary to 3-digit BCD, shift-add-3 one bit per cycle.
// bcd is valid while done is high (the single DONE cycle).
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    bcd_state_t  state;
    logic [19:0] work;
    logic [2:0]  iter;
    logic [19:0] adj;

    assign adj  = {add3(work[19:8]), work[7:0]};
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign bcd  = work[19:8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            work  <= '0;
            iter  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    work  <= {12'd0, bin};
                    iter  <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    work  <= adj << 1;
                    iter  <= iter + 3'd1;
                    state <= iter == 3'd7 ? DONE : SHIFT;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// score_display: 4-digit multiplexed seven-segment driver (score hundreds/tens/ones, lives).
// Define SCORE_DISPLAY_BLINK_EN to blink the whole display while a game-over flag is set.
module score_display
    import score_display_pkg::*;
#(
    parameter int DIGIT_PERIOD = DEF_DIGIT_PERIOD,
    parameter int GUARD        = DEF_GUARD,
    parameter int BLINK_PERIOD = DEF_BLINK_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] score,
    input  logic [1:0] lives,
    input  logic       ball_lost,
    input  logic       game_won,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = DIGIT_PERIOD > 1 ? $clog2(DIGIT_PERIOD) : 1;

    logic [7:0]    latched;
    logic          busy;
    logic          done;
    logic          start;
    logic [11:0]   conv;
    logic [11:0]   disp;
    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic          blink_cond;
    logic          blink_off;
    logic [3:0]    ones;
    logic [3:0]    tens;
    logic [3:0]    hund;
    logic [6:0]    seg_cur;

    assign start      = !busy && score != latched;
    assign blink_cond = game_won || ball_lost;

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (score),
        .busy  (busy),
        .done  (done),
        .bcd   (conv)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            latched <= '0;
            disp    <= '0;
        end else begin
            if (start)
                latched <= score;
            if (done)
                disp <= conv;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            digit <= '0;
        end else if (cnt == CW'(DIGIT_PERIOD - 1)) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int BW = BLINK_PERIOD > 1 ? $clog2(BLINK_PERIOD) : 1;

    logic [BW-1:0] bcnt;
    logic          phase;

    // Cleared whenever the condition drops so the next blink starts in the on phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!blink_cond) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BW'(BLINK_PERIOD - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    assign blink_off = blink_cond && phase;
`else
    // Blinking compiled out; a zero period is the only degenerate case left referenced.
    assign blink_off = blink_cond && BLINK_PERIOD == 0;
`endif

    assign {hund, tens, ones} = disp;

    assign seg_cur = digit == 2'd0 ? seg_of(ones) :
                     digit == 2'd1 ? (hund == 4'd0 && tens == 4'd0 ? SEG_BLANK : seg_of(tens)) :
                     digit == 2'd2 ? (hund == 4'd0 ? SEG_BLANK : seg_of(hund)) :
                                     seg_of({2'b00, lives});

    assign an  = !reset || cnt < CW'(GUARD) || blink_off ? 4'b1111 : ~(4'b0001 << digit);
    assign seg = !reset ? SEG_BLANK : seg_cur;
    assign dp  = !reset || !(digit == 2'd3 && ball_lost);

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: random stimulus against a decimal/counting model of the display.
module tb_score_display;

    localparam int DP = 8;
    localparam int GD = 2;
    localparam int BP = 32;
    localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] score = 8'd0;
    logic [1:0] lives = 2'd3;
    logic       ball_lost = 1'b0;
    logic       game_won = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int passes = 0;
    int total = 0;
    bit go = 1'b0;

    // model: edges since reset, displayed value, pending conversion, blink age
    int n = 0;
    int m_disp = 0;
    int m_lat = 0;
    int m_pend = 0;
    int m_rem = 0;
    int bcount = 0;

    score_display #(.DIGIT_PERIOD(DP), .GUARD(GD), .BLINK_PERIOD(BP)) dut (
        .clk       (clk),
        .reset     (reset),
        .score     (score),
        .lives     (lives),
        .ball_lost (ball_lost),
        .game_won  (game_won),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // A conversion accepted at one edge becomes visible after the tenth edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n <= 0; m_disp <= 0; m_lat <= 0; m_pend <= 0; m_rem <= 0; bcount <= 0;
        end else begin
            n <= n + 1;
            bcount <= (game_won || ball_lost) ? bcount + 1 : 0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) m_disp <= m_pend;
            end else if (int'(score) != m_lat) begin
                m_lat <= int'(score);
                m_pend <= int'(score);
                m_rem <= 9;
            end
        end
    end

    always @(negedge clk) begin
        int dig, pos;
        logic blink;
        logic [6:0] es;
        logic [3:0] ea;
        if (go) begin
            if (!reset) begin
                chk("rst_an", an, 4'hf);
                chk("rst_seg", seg, 7'h7f);
                chk("rst_dp", dp, 1);
            end else begin
                dig = (n / DP) % 4;
                pos = n % DP;
`ifdef SCORE_DISPLAY_BLINK_EN
                blink = (game_won || ball_lost) && ((bcount / BP) % 2 == 1);
`else
                blink = 1'b0;
`endif
                ea = (pos < GD || blink) ? 4'hf : ~(4'b0001 << dig);
                es = dig == 0 ? SEGS[m_disp % 10] :
                     dig == 1 ? (m_disp < 10 ? 7'h7f : SEGS[(m_disp / 10) % 10]) :
                     dig == 2 ? (m_disp < 100 ? 7'h7f : SEGS[m_disp / 100]) :
                                SEGS[lives];
                chk("an", an, ea);
                chk("seg", seg, es);
                chk("dp", dp, (dig == 3 && ball_lost) ? 1'b0 : 1'b1);
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic wait_slot(input int d);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (n % (4 * DP) != d * DP + GD + 1 && k < 8 * DP);
        if (k >= 8 * DP) chk("slot_timeout", k, 0);
    endtask

    initial begin
        #1 go = 1'b1;
        #10;
        chk("lit_rst_an", an, 4'b1111);
        chk("lit_rst_seg", seg, 7'b1111111);
        chk("lit_rst_dp", dp, 1'b1);
        cyc(1);
        reset = 1'b1;

        wait_slot(0);
        chk("lit_d0_seg", seg, 7'b1000000);
        chk("lit_d0_an", an, 4'b1110);
        wait_slot(1);
        chk("lit_d1_blank", seg, 7'b1111111);
        chk("lit_d1_an", an, 4'b1101);
        wait_slot(2);
        chk("lit_d2_blank", seg, 7'b1111111);
        chk("lit_d2_an", an, 4'b1011);
        wait_slot(3);
        chk("lit_d3_lives", seg, 7'b0110000);
        chk("lit_d3_an", an, 4'b0111);
        @(negedge clk);
        while (n % DP != 0) @(negedge clk);
        chk("lit_guard0", an, 4'b1111);
        @(negedge clk);
        chk("lit_guard1", an, 4'b1111);

        cyc(1); score = 8'd9; cyc(12);
        score = 8'd10;
        repeat (9) @(posedge clk);
        #1 chk("lit_lat9", m_disp, 9);
        @(posedge clk);
        #1 chk("lit_lat10", m_disp, 10);
        wait_slot(1);
        chk("lit_tens1", seg, 7'b1111001);
        wait_slot(0);
        chk("lit_ones0", seg, 7'b1000000);

        cyc(1); score = 8'd255; cyc(3); score = 8'd254;
        repeat (7) @(posedge clk);
        #1 chk("lit_255", m_disp, 255);
        repeat (10) @(posedge clk);
        #1 chk("lit_254", m_disp, 254);
        wait_slot(2);
        chk("lit_h2", seg, 7'b0100100);
        wait_slot(0);
        chk("lit_o4", seg, 7'b0011001);

        cyc(1); ball_lost = 1'b1; lives = 2'd0;
        wait_slot(3);
        chk("lit_dp_on", dp, 1'b0);
        chk("lit_lives0", seg, 7'b1000000);
        wait_slot(0);
        chk("lit_dp_off", dp, 1'b1);
        game_won = 1'b1;
        cyc(3 * BP);
        cyc(1); ball_lost = 1'b0; game_won = 1'b0;

        for (int i = 0; i < 700; i++) begin
            cyc(1);
            if ($urandom_range(0, 7) == 0) score = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) lives = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 47) == 0) ball_lost = ~ball_lost;
            if ($urandom_range(0, 63) == 0) game_won = ~game_won;
        end
        ball_lost = 1'b0; game_won = 1'b0;
        cyc(20);

        score = 8'd123; cyc(4);
        reset = 1'b0;
        #1;
        chk("lit_mid_an", an, 4'b1111);
        chk("lit_mid_seg", seg, 7'b1111111);
        chk("lit_mid_dp", dp, 1'b1);
        cyc(3);
        reset = 1'b1;
        cyc(12);
        #1 chk("lit_reconv", m_disp, 123);
        wait_slot(2);
        chk("lit_h1", seg, 7'b1111001);
        cyc(40);

        go = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
